rc4_ksa_fsm: RTL and testbench

Parametrised RC4 state-array initialiser and key scheduler driving an external single-port synchronous RAM (S memory, 2^DATA_W words × DATA_W bits).
- Mode 0: fills S[i] = i only.
- Mode 1: fills S[i] = i, then runs the full key-scheduling swap pass with a KEY_LEN-element key.
- Sits between the top-level control FSM (start/done handshake) and the S-memory port, and is reused by the decrypt and key-search stages.

---
 rtl/rc4_ksa_fsm.sv | 144 ++++++++++++++
 tb/tb_rc4_ksa_fsm.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_ksa_fsm.sv
// RC4 S-array initialiser and key scheduler driving a single-port synchronous S memory.
// Mode 0 fills S[i] = i; mode 1 follows the fill with the full key-scheduling swap pass.
module rc4_ksa_fsm #(
    parameter int DATA_W  = 8,
    parameter int KEY_LEN = 3
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        start,
    input  logic                        mode,
    input  logic [KEY_LEN*DATA_W-1:0]   key,
    output logic [DATA_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wrdata,
    output logic                        mem_wren,
    input  logic [DATA_W-1:0]           mem_rddata,
    output logic                        busy,
    output logic                        done
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT,
        S_RD_I,
        S_WAIT_I,
        S_RD_J,
        S_WAIT_J,
        S_WR_I,
        S_WR_J,
        S_DONE
    } state_t;

    localparam logic [DATA_W-1:0] LAST_IDX = '1;

    state_t                      state;
    state_t                      state_nx;
    logic [DATA_W-1:0]           i;
    logic [DATA_W-1:0]           j;
    logic [DATA_W-1:0]           si;
    logic [DATA_W-1:0]           sj;
    logic [KEY_LEN*DATA_W-1:0]   key_q;
    logic                        mode_q;
    logic [DATA_W-1:0]           key_sel;
    int                          key_pos;

    // Key element 0 sits in the most-significant slice of the latched key.
    always_comb begin
        key_pos = (KEY_LEN - 1 - (int'(i) % KEY_LEN)) * DATA_W;
        key_sel = key_q[key_pos +: DATA_W];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // NOTE: all outputs and next state get a default first so no path through the case infers a latch.
    always_comb begin
        state_nx   = state;
        mem_addr   = '0;
        mem_wrdata = '0;
        mem_wren   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) state_nx = S_INIT;
            end
            S_INIT: begin
                mem_addr   = i;
                mem_wrdata = i;
                mem_wren   = 1'b1;
                if (i == LAST_IDX) state_nx = mode_q ? S_RD_I : S_DONE;
            end
            S_RD_I: begin
                mem_addr = i;
                state_nx = S_WAIT_I;
            end
            S_WAIT_I: begin
                mem_addr = i;
                state_nx = S_RD_J;
            end
            S_RD_J: begin
                mem_addr = j;
                state_nx = S_WAIT_J;
            end
            S_WAIT_J: begin
                mem_addr = j;
                state_nx = S_WR_I;
            end
            S_WR_I: begin
                mem_addr   = i;
                mem_wrdata = sj;
                mem_wren   = 1'b1;
                state_nx   = S_WR_J;
            end
            S_WR_J: begin
                mem_addr   = j;
                mem_wrdata = si;
                mem_wren   = 1'b1;
                state_nx   = (i == LAST_IDX) ? S_DONE : S_RD_I;
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    // Datapath; i wraps naturally to 0 at the end of the fill so the swap pass restarts at index 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            i      <= '0;
            j      <= '0;
            si     <= '0;
            sj     <= '0;
            key_q  <= '0;
            mode_q <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        mode_q <= mode;
                        key_q  <= key;
                        i      <= '0;
                        j      <= '0;
                    end
                end
                S_INIT: i <= i + 1'b1;
                S_WAIT_I: begin
                    si <= mem_rddata;
                    j  <= j + mem_rddata + key_sel;
                end
                S_WAIT_J: sj <= mem_rddata;
                S_WR_J:   i  <= i + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rc4_ksa_fsm.sv
// Directed bench for rc4_ksa_fsm: a 2-bit/1-key instance and an 8-bit/3-key instance,
// each attached to its own synchronous single-port RAM model.
module tb_rc4_ksa_fsm;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    // Small instance: DATA_W=2, KEY_LEN=1
    logic       start_s, mode_s, wren_s, busy_s, done_s;
    logic [1:0] key_s, addr_s, wrdata_s, rd_s;
    logic [1:0] mem_s [4];

    // Large instance: DATA_W=8, KEY_LEN=3
    logic        start_b, mode_b, wren_b, busy_b, done_b;
    logic [23:0] key_b;
    logic [7:0]  addr_b, wrdata_b, rd_b;
    logic [7:0]  mem_b [256];
    logic [7:0]  exp_s [256];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int wa_s[$], wd_s[$], wc_s[$];
    int wn_b = 0;
    int abort_addr = -1;

    rc4_ksa_fsm #(.DATA_W(2), .KEY_LEN(1)) u_small (
        .clk(clk), .reset_n(reset_n), .start(start_s), .mode(mode_s), .key(key_s),
        .mem_addr(addr_s), .mem_wrdata(wrdata_s), .mem_wren(wren_s), .mem_rddata(rd_s),
        .busy(busy_s), .done(done_s)
    );

    rc4_ksa_fsm #(.DATA_W(8), .KEY_LEN(3)) u_big (
        .clk(clk), .reset_n(reset_n), .start(start_b), .mode(mode_b), .key(key_b),
        .mem_addr(addr_b), .mem_wrdata(wrdata_b), .mem_wren(wren_b), .mem_rddata(rd_b),
        .busy(busy_b), .done(done_b)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (wren_s) begin
            mem_s[addr_s] <= wrdata_s;
            wa_s.push_back(int'(addr_s));
            wd_s.push_back(int'(wrdata_s));
            wc_s.push_back(cyc);
        end
        rd_s <= mem_s[addr_s];
    end

    always @(posedge clk) begin
        if (wren_b) begin
            mem_b[addr_b] <= wrdata_b;
            wn_b <= wn_b + 1;
        end
        rd_b <= mem_b[addr_b];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Reference RC4 key schedule for 256 entries with a 3-byte key.
    task automatic ksa_model(input logic [23:0] k);
        int jj = 0;
        logic [7:0] t;
        for (int n = 0; n < 256; n++) exp_s[n] = 8'(n);
        for (int n = 0; n < 256; n++) begin
            jj = (jj + int'(exp_s[n]) + int'(k[(2 - (n % 3)) * 8 +: 8])) % 256;
            t         = exp_s[n];
            exp_s[n]  = exp_s[jj];
            exp_s[jj] = t;
        end
    endtask

    task automatic check_big_s(input string tag);
        int seen [256];
        int distinct = 0;
        for (int n = 0; n < 256; n++) seen[n] = 0;
        for (int n = 0; n < 256; n++) begin
            check($sformatf("%s_s%0d", tag, n), int'(mem_b[n]), int'(exp_s[n]));
            seen[mem_b[n]]++;
        end
        for (int n = 0; n < 256; n++) if (seen[n] == 1) distinct++;
        check({tag, "_perm"}, distinct, 256);
    endtask

    // Launch one job; optionally pulse start with a new key mid-run, or abort with reset.
    task automatic run_job(input bit big, input bit md, input logic [23:0] k,
                           input int pulse_at, input logic [23:0] k2, input int abort_at,
                           output int lat, output int busy_n, output int done_n);
        logic bz, dz;
        @(negedge clk);
        wa_s.delete(); wd_s.delete(); wc_s.delete();
        wn_b = 0;
        if (big) begin start_b = 1'b1; mode_b = md; key_b = k; end
        else     begin start_s = 1'b1; mode_s = md; key_s = k[1:0]; end
        @(posedge clk); #1;
        start_s = 1'b0; start_b = 1'b0;
        lat = -1; done_n = 0;
        busy_n = (big ? busy_b : busy_s) ? 1 : 0;
        for (int n = 1; n <= 2500; n++) begin
            @(posedge clk); #1;
            if (big) start_b = 1'b0;
            bz = big ? busy_b : busy_s;
            dz = big ? done_b : done_s;
            if (n == abort_at) begin
                abort_addr = int'(addr_b);
                #2 reset_n = 1'b0;
                #1;
                lat = -2;
                break;
            end
            if (n == pulse_at) begin
                start_b = 1'b1; key_b = k2; mode_b = 1'b0;
            end
            if (bz) busy_n++;
            if (dz) begin
                done_n++;
                if (lat < 0) lat = n;
            end
            if (lat >= 0 && !bz) break;
        end
        if (lat == -1) check("timeout", 0, 1);
    endtask

    int lat, bn, dn;
    int jseq0 [4] = '{0, 1, 3, 1};
    int jseq1 [4] = '{1, 2, 3, 0};
    int fin   [4] = '{0, 2, 3, 1};

    initial begin
        for (int n = 0; n < 4; n++) mem_s[n] = 2'd3;
        for (int n = 0; n < 256; n++) mem_b[n] = 8'hAA;
        start_s = 0; mode_s = 0; key_s = '0;
        start_b = 0; mode_b = 0; key_b = '0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy_s", busy_s, 0);
        check("rst_done_s", done_s, 0);
        check("rst_wren_s", wren_s, 0);
        check("rst_addr_b", addr_b, 0);
        check("rst_wrdata_b", wrdata_b, 0);
        check("rst_busy_b", busy_b, 0);
        @(negedge clk) reset_n = 1'b1;

        // Mode 0 fill on the 4-entry memory
        run_job(0, 0, 24'h0, -1, 24'h0, -1, lat, bn, dn);
        check("m0_latency", lat, 4);
        check("m0_busy_cycles", bn, 5);
        check("m0_done_pulses", dn, 1);
        check("m0_writes", wa_s.size(), 4);
        if (wa_s.size() == 4) begin
            for (int n = 0; n < 4; n++) begin
                check($sformatf("m0_waddr%0d", n), wa_s[n], n);
                check($sformatf("m0_wdata%0d", n), wd_s[n], n);
                check($sformatf("m0_wcyc%0d", n), wc_s[n] - wc_s[0], n);
            end
        end
        for (int n = 0; n < 4; n++) check($sformatf("m0_s%0d", n), mem_s[n], n);

        // Mode 1, key 0
        run_job(0, 1, 24'h0, -1, 24'h0, -1, lat, bn, dn);
        check("k0_latency", lat, 28);
        check("k0_busy_cycles", bn, 29);
        check("k0_done_pulses", dn, 1);
        check("k0_writes", wa_s.size(), 12);
        if (wa_s.size() == 12)
            for (int n = 0; n < 4; n++) check($sformatf("k0_j%0d", n), wa_s[5 + 2*n], jseq0[n]);
        for (int n = 0; n < 4; n++) check($sformatf("k0_s%0d", n), mem_s[n], fin[n]);

        // Mode 1, key 1
        run_job(0, 1, 24'h1, -1, 24'h0, -1, lat, bn, dn);
        check("k1_latency", lat, 28);
        check("k1_writes", wa_s.size(), 12);
        if (wa_s.size() == 12) begin
            check("k1_i0_wr_addr_i", wa_s[4], 0);
            check("k1_i0_wr_data_i", wd_s[4], 1);
            check("k1_i0_wr_addr_j", wa_s[5], 1);
            check("k1_i0_wr_data_j", wd_s[5], 0);
            for (int n = 0; n < 4; n++) check($sformatf("k1_j%0d", n), wa_s[5 + 2*n], jseq1[n]);
        end
        for (int n = 0; n < 4; n++) check($sformatf("k1_s%0d", n), mem_s[n], fin[n]);

        // Full-size key schedule
        run_job(1, 1, 24'h000249, -1, 24'h0, -1, lat, bn, dn);
        check("big_latency", lat, 1792);
        check("big_busy_cycles", bn, 1793);
        check("big_done_pulses", dn, 1);
        check("big_writes", wn_b, 768);
        ksa_model(24'h000249);
        check_big_s("big");

        // Abort with reset at i=100 (RD_I presents i), then restart from scratch
        run_job(1, 1, 24'h000249, -1, 24'h0, 256 + 600, lat, bn, dn);
        check("abort_reached", lat, -2);
        check("abort_addr_i", abort_addr, 100);
        check("abort_busy", busy_b, 0);
        check("abort_done", done_b, 0);
        check("abort_wren", wren_b, 0);
        check("abort_addr", addr_b, 0);
        check("abort_wrdata", wrdata_b, 0);
        @(negedge clk) reset_n = 1'b1;
        run_job(1, 1, 24'h000249, -1, 24'h0, -1, lat, bn, dn);
        check("restart_latency", lat, 1792);
        check_big_s("restart");

        // start pulse plus key/mode change mid-run must not disturb the job
        run_job(1, 1, 24'h1A2B3C, 500, 24'hFFFFFF, -1, lat, bn, dn);
        check("midrun_latency", lat, 1792);
        check("midrun_done_pulses", dn, 1);
        check("midrun_idle_after", busy_b, 0);
        ksa_model(24'h1A2B3C);
        check_big_s("midrun");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
